// File: rtl/noise_pkg.sv
// Shared definitions for the noise parameter loader: word width, default
// parameters and the controller state encoding.
package noise_pkg;

  localparam int WORD_W      = 16;
  localparam int NWORDS_DEF  = 8;
  localparam int GAP_DEF     = 3;
  localparam int START_W_DEF = 2;
  localparam int TO_W_DEF    = 24;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/noise_param_loader_if.sv
// Host bus plus sequencer load/start signals seen by the loader.
// master = the loader itself, slave = the host/sequencer side.
interface noise_param_loader_if
  import noise_pkg::*;
#(
  parameter int NWORDS = NWORDS_DEF
);

  logic                      host_we;
  logic [$clog2(NWORDS)-1:0] host_addr;
  word_t                     host_data;
  logic [NWORDS-1:0]         host_chmask;
  logic [$clog2(NWORDS):0]   host_cnt;
  logic                      host_go;
  logic                      host_abort;

  word_t                     ndatain;
  logic                      nload;
  logic                      nchoice;
  logic                      noisestart;
  logic                      interrupt;

  logic                      busy;
  logic                      done;
  logic                      timeout;
  logic                      aborted;

  modport master (
    input  host_we, host_addr, host_data, host_chmask, host_cnt, host_go, host_abort,
    input  interrupt,
    output ndatain, nload, nchoice, noisestart,
    output busy, done, timeout, aborted
  );

  modport slave (
    output host_we, host_addr, host_data, host_chmask, host_cnt, host_go, host_abort,
    output interrupt,
    input  ndatain, nload, nchoice, noisestart,
    input  busy, done, timeout, aborted
  );

endinterface

// File: rtl/noise_param_buf.sv
// NWORDS x 16 parameter buffer: synchronous write, combinational read.
// Contents are deliberately not reset.
module noise_param_buf
  import noise_pkg::*;
#(
  parameter int NWORDS = NWORDS_DEF
) (
  input  logic                      clk_sys,
  input  logic                      we_i,
  input  logic [$clog2(NWORDS)-1:0] waddr_i,
  input  word_t                     wdata_i,
  input  logic [$clog2(NWORDS)-1:0] raddr_i,
  output word_t                     rdata_o
);

  word_t mem_q [NWORDS];

  always_ff @(posedge clk_sys) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/noise_param_loader.sv
// Serializes the host parameter buffer onto the sequencer load interface,
// pulses noisestart and waits for the sequencer interrupt or a timeout.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | host may write the buffer; waits for host_go
//   S_LOAD  | one nload strobe per word, GAP hold cycles between strobes
//   S_START | noisestart high for START_W cycles
//   S_WAIT  | waits for an interrupt rising edge or timer expiry
module noise_param_loader
  import noise_pkg::*;
#(
  parameter int NWORDS  = NWORDS_DEF,
  parameter int GAP     = GAP_DEF,
  parameter int START_W = START_W_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic                 clk_sys,
  input  logic                 noiserst,
  noise_param_loader_if.master bus
);

  localparam int AW = $clog2(NWORDS);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP + 1);
  localparam int SW = $clog2(START_W + 1);

  logic [1:0]        state_q,    state_d;
  logic [CW-1:0]     idx_q,      idx_d;
  logic [CW-1:0]     cnt_q,      cnt_d;
  logic [NWORDS-1:0] chmask_q,   chmask_d;
  logic [GW-1:0]     gap_q,      gap_d;
  logic [SW-1:0]     st_q,       st_d;
  logic [TO_W-1:0]   wcnt_q,     wcnt_d;
  logic              int_prev_q, int_prev_d;
  word_t             ndat_q,     ndat_d;
  logic              nchoice_q,  nchoice_d;
  logic              done_q,     done_d;
  logic              aborted_q,  aborted_d;
  logic              timeout_q,  timeout_d;

  word_t rd_data;
  logic  buf_we;
  logic  irq_edge;
  logic  last_word;
  logic  cur_choice;

  // Writes are gated to IDLE so the buffer is stable while words are sent.
  assign buf_we = bus.host_we && (state_q == S_IDLE);

  noise_param_buf #(
    .NWORDS (NWORDS)
  ) u_buf (
    .clk_sys (clk_sys),
    .we_i    (buf_we),
    .waddr_i (bus.host_addr),
    .wdata_i (bus.host_data),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  assign irq_edge   = (state_q == S_WAIT) && bus.interrupt && !int_prev_q;
  assign last_word  = (idx_q + CW'(1)) == cnt_q;
  assign cur_choice = chmask_q[idx_q[AW-1:0]];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    chmask_d   = chmask_q;
    gap_d      = gap_q;
    st_d       = st_q;
    wcnt_d     = wcnt_q;
    int_prev_d = int_prev_q;
    ndat_d     = ndat_q;
    nchoice_d  = nchoice_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    timeout_d  = timeout_q;

    if ((state_q != S_IDLE) && bus.host_abort) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.host_go) begin
            cnt_d     = bus.host_cnt;
            chmask_d  = bus.host_chmask;
            timeout_d = 1'b0;
            idx_d     = '0;
            gap_d     = '0;
            st_d      = '0;
            state_d   = (bus.host_cnt == '0) ? S_START : S_LOAD;
          end
        end

        S_LOAD: begin
          ndat_d    = rd_data;
          nchoice_d = cur_choice;
          // The last word goes straight to START without trailing hold cycles.
          if ((gap_q == '0) && last_word) begin
            st_d    = '0;
            state_d = S_START;
          end else if (gap_q == GW'(GAP)) begin
            gap_d = '0;
            idx_d = idx_q + CW'(1);
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end

        S_START: begin
          if (st_q == SW'(START_W - 1)) begin
            wcnt_d     = '0;
            int_prev_d = 1'b0;
            state_d    = S_WAIT;
          end else begin
            st_d = st_q + SW'(1);
          end
        end

        S_WAIT: begin
          int_prev_d = bus.interrupt;
          wcnt_d     = wcnt_q + TO_W'(1);
          // Edge beats expiry when both land on the same cycle.
          if (irq_edge) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (wcnt_q == {{(TO_W-1){1'b1}}, 1'b0}) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (noiserst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      chmask_q   <= '0;
      gap_q      <= '0;
      st_q       <= '0;
      wcnt_q     <= '0;
      int_prev_q <= 1'b0;
      ndat_q     <= '0;
      nchoice_q  <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      chmask_q   <= chmask_d;
      gap_q      <= gap_d;
      st_q       <= st_d;
      wcnt_q     <= wcnt_d;
      int_prev_q <= int_prev_d;
      ndat_q     <= ndat_d;
      nchoice_q  <= nchoice_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      timeout_q  <= timeout_d;
    end
  end

  // Read the buffer live during LOAD so a write issued with host_go is seen.
  assign bus.ndatain    = (state_q == S_LOAD) ? rd_data : ndat_q;
  assign bus.nchoice    = (state_q == S_LOAD) ? cur_choice : nchoice_q;
  assign bus.nload      = (state_q == S_LOAD) && (gap_q == '0);
  assign bus.noisestart = (state_q == S_START);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.aborted    = aborted_q;

endmodule

// File: tb/tb_noise_param_loader.sv
// Scoreboard bench for noise_param_loader: a timeline model predicts output
// events per transaction and a monitor matches what the DUT presents.
module tb_noise_param_loader;
  import noise_pkg::*;

  localparam int NW      = 8;
  localparam int GAP     = 3;
  localparam int START_W = 2;
  localparam int TO_W    = 7;
  localparam int TMAX    = (1 << TO_W) - 1;
  localparam int NO_IRQ  = -1000;

  typedef enum int {EV_TCLR, EV_BUSY, EV_LOAD, EV_NSR, EV_NSF,
                    EV_DONE, EV_TOUT, EV_ABORT, EV_IDLE} ev_e;
  typedef struct {
    ev_e         kind;
    int          cyc;
    logic [15:0] data;
    logic        ch;
  } ev_t;

  logic clk_sys  = 1'b0;
  logic noiserst = 1'b1;
  int   cyc      = 0;
  int   vectors  = 0;
  int   miscompares = 0;
  bit   mon_en   = 1'b0;

  ev_t         exp_q[$];
  logic [15:0] mbuf[NW];
  logic [15:0] last_word = 16'h0;
  bit          tflag = 1'b0;

  noise_param_loader_if #(.NWORDS(NW)) bus ();

  noise_param_loader #(
    .NWORDS  (NW),
    .GAP     (GAP),
    .START_W (START_W),
    .TO_W    (TO_W)
  ) dut (
    .clk_sys  (clk_sys),
    .noiserst (noiserst),
    .bus      (bus)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic push(input ev_e k, input int c, input logic [15:0] d, input logic ch);
    ev_t e;
    e.kind = k; e.cyc = c; e.data = d; e.ch = ch;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_e k, input logic [15:0] d, input logic ch);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got %s at cycle %0d data=%h ch=%b, required none", k.name(), cyc, d, ch);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc ||
          ((k == EV_LOAD || k == EV_IDLE) && e.data != d) ||
          (k == EV_LOAD && e.ch != ch)) begin
        miscompares++;
        $display("FAIL event_%s: got %s cyc=%0d data=%h ch=%b, required %s cyc=%0d data=%h ch=%b",
                 e.kind.name(), k.name(), cyc, d, ch, e.kind.name(), e.cyc, e.data, e.ch);
      end
    end
  endtask

  logic busy_p = 1'b0, ns_p = 1'b0, tout_p = 1'b0;

  always @(negedge clk_sys) begin
    if (mon_en) begin
      if (tout_p && !bus.timeout)     observe(EV_TCLR, 16'h0, 1'b0);
      if (!busy_p && bus.busy)        observe(EV_BUSY, 16'h0, 1'b0);
      if (bus.nload)                  observe(EV_LOAD, bus.ndatain, bus.nchoice);
      if (!ns_p && bus.noisestart)    observe(EV_NSR, 16'h0, 1'b0);
      if (ns_p && !bus.noisestart)    observe(EV_NSF, 16'h0, 1'b0);
      if (bus.done)                   observe(EV_DONE, 16'h0, 1'b0);
      if (!tout_p && bus.timeout)     observe(EV_TOUT, 16'h0, 1'b0);
      if (bus.aborted)                observe(EV_ABORT, 16'h0, 1'b0);
      if (busy_p && !bus.busy)        observe(EV_IDLE, bus.ndatain, 1'b0);
      if (bus.nload && bus.noisestart) begin
        miscompares++;
        $display("FAIL load_start_overlap: got nload=1 noisestart=1 at cycle %0d, required not both", cyc);
      end
    end
    busy_p <= bus.busy;
    ns_p   <= bus.noisestart;
    tout_p <= bus.timeout;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    bus.host_we   = 1'b1;
    bus.host_addr = 3'(a);
    bus.host_data = d;
    mbuf[a] = d;
    step();
    bus.host_we = 1'b0;
  endtask

  // Predict one transaction from the timing rules, then drive it cycle by cycle.
  task automatic txn(input int n, input logic [NW-1:0] mask, input int kill_off,
                     input bit kill_rst, input int irq_off, input bit wwg,
                     input logic [15:0] wwg_data, input bit poke);
    int g, s, w, e, endc, k, endk, r, t;
    bit killed, irq, pk;
    g = cyc;
    if (wwg) mbuf[0] = wwg_data;
    s = (n == 0) ? g + 1 : g + 1 + (GAP + 1) * (n - 1) + 1;
    w = s + START_W;
    irq = (irq_off != NO_IRQ);
    if (irq) begin
      r = w + irq_off;
      e = (r > w) ? r : w;
      endc = e + 1;
    end else begin
      r = 0;
      e = 0;
      endc = w + TMAX;
    end
    killed = (kill_off > 0) && (g + kill_off < endc);
    k    = killed ? g + kill_off : 0;
    endk = killed ? k + 1 : endc;

    if (tflag) push(EV_TCLR, g + 1, 16'h0, 1'b0);
    tflag = 1'b0;
    push(EV_BUSY, g + 1, 16'h0, 1'b0);
    for (int j = 0; j < n; j++) begin
      t = g + 1 + (GAP + 1) * j;
      if (!killed || t <= k) begin
        push(EV_LOAD, t, mbuf[j], mask[j]);
        last_word = mbuf[j];
      end
    end
    if (!killed || s <= k) push(EV_NSR, s, 16'h0, 1'b0);
    if (!killed || w <= k) push(EV_NSF, w, 16'h0, 1'b0);
    else if (s <= k)       push(EV_NSF, k + 1, 16'h0, 1'b0);
    if (killed) begin
      if (kill_rst) last_word = 16'h0;
      else          push(EV_ABORT, k + 1, 16'h0, 1'b0);
      push(EV_IDLE, k + 1, last_word, 1'b0);
    end else begin
      if (irq) push(EV_DONE, endc, 16'h0, 1'b0);
      else begin
        push(EV_TOUT, endc, 16'h0, 1'b0);
        tflag = 1'b1;
      end
      push(EV_IDLE, endc, last_word, 1'b0);
    end

    for (int c = g; c <= endk + 2; c++) begin
      pk = poke && (c == w + 2) && (w + 2 < endk);
      bus.host_go     = (c == g) || pk;
      bus.host_we     = (c == g && wwg) || pk;
      bus.host_addr   = 3'd0;
      bus.host_data   = pk ? 16'($urandom) : wwg_data;
      bus.host_cnt    = pk ? 4'($urandom_range(1, 8)) : 4'(n);
      bus.host_chmask = pk ? 8'($urandom) : mask;
      bus.host_abort  = killed && !kill_rst && (c == k);
      noiserst        = killed && kill_rst && (c == k);
      bus.interrupt   = irq && (c >= r);
      step();
    end
    bus.host_go = 1'b0; bus.host_we = 1'b0; bus.host_abort = 1'b0;
    bus.interrupt = 1'b0; noiserst = 1'b0;
    step();
  endtask

  initial begin
    int n, koff, ioff;
    bit krst;
    bus.host_we = 1'b0; bus.host_addr = '0; bus.host_data = '0;
    bus.host_chmask = '0; bus.host_cnt = '0; bus.host_go = 1'b0;
    bus.host_abort = 1'b0; bus.interrupt = 1'b0;
    repeat (3) step();
    check("rst_ndatain", 32'(bus.ndatain), 32'h0);
    check("rst_nload", 32'(bus.nload), 32'h0);
    check("rst_nchoice", 32'(bus.nchoice), 32'h0);
    check("rst_noisestart", 32'(bus.noisestart), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_timeout", 32'(bus.timeout), 32'h0);
    check("rst_aborted", 32'(bus.aborted), 32'h0);
    noiserst = 1'b0;
    step();
    mon_en = 1'b1;

    for (int a = 0; a < NW; a++) wr(a, 16'($urandom));
    wr(0, 16'h1234); wr(1, 16'hABCD); wr(2, 16'h00FF);
    txn(3, 8'b0000_0010, -1, 0, 50, 0, 16'h0, 0);
    txn(1, 8'($urandom), -1, 0, NO_IRQ, 0, 16'h0, 0);
    txn(2, 8'($urandom), -1, 0, 5, 0, 16'h0, 0);
    txn(3, 8'($urandom), 6, 0, 10, 0, 16'h0, 0);
    txn(0, 8'($urandom), -1, 0, 20, 0, 16'h0, 1);
    txn(2, 8'($urandom), 6, 1, 10, 0, 16'h0, 0);
    txn(1, 8'($urandom), -1, 0, 0, 0, 16'h0, 0);
    txn(2, 8'($urandom), -1, 0, -3, 0, 16'h0, 0);
    txn(1, 8'($urandom), -1, 0, TMAX - 1, 0, 16'h0, 0);
    txn(2, 8'($urandom), -1, 0, 3, 1, 16'hBEEF, 0);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) wr($urandom_range(0, NW - 1), 16'($urandom));
      n    = $urandom_range(0, NW);
      koff = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 25) : -1;
      krst = $urandom_range(0, 1);
      ioff = ($urandom_range(0, 9) == 0) ? NO_IRQ : $urandom_range(0, 40) - 2;
      txn(n, 8'($urandom), koff, krst, ioff, $urandom_range(0, 3) == 0,
          16'($urandom), $urandom_range(0, 2) == 0);
    end

    repeat (5) step();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_events: got %0d unmatched, required 0 (next %s at cycle %0d)",
               exp_q.size(), exp_q[0].kind.name(), exp_q[0].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
